// File: rtl/ro_pkg.sv
// Shared definitions for the readout-bus capture path: default geometry,
// FSM state encoding and the slot counter width helper.
package ro_pkg;

  localparam int RO_NSLOT = 16;
  localparam int RO_BUSW  = 2;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_WAIT_ENC    = 2'd1;
  localparam logic [1:0] ST_CAPTURE_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_WAIT    = ST_WAIT_ENC,
    ST_CAPTURE = ST_CAPTURE_ENC,
    ST_DONE    = ST_DONE_ENC
  } ro_state_e;

  // Slot counter must be able to hold NSLOT itself (the "not capturing" value).
  function automatic int ro_cnt_w(input int nslot);
    return $clog2(nslot + 1);
  endfunction

endpackage

// File: rtl/ro_out_skid.sv
// One-entry valid/ready holding register for completed frames. A new frame
// is taken when the register is empty or being drained in the same cycle;
// otherwise the new frame is dropped and overrun pulses for one cycle.
module ro_out_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         overrun
);

  logic take;

  assign take = load & (~out_valid | out_ready);

  // Holding register: load wins over accept so a simultaneous accept+load keeps valid high.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= load & out_valid & ~out_ready;
      if (take) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ro_bus_capture.sv
// Receive end of the shared readout bus. A rising edge of frame_sync starts a
// frame; after SKEW cycles one BUSW-bit slot is sampled per clk into a shift
// register, and the packed frame is handed to the output holding register.
module ro_bus_capture
  import ro_pkg::*;
#(
  parameter int NSLOT = RO_NSLOT,
  parameter int BUSW  = RO_BUSW,
  parameter int SKEW  = 1
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       frame_sync,
  input  logic [BUSW-1:0]            bus_in,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [NSLOT*BUSW-1:0]      out_data,
  output logic [$clog2(NSLOT+1)-1:0] slot_idx,
  output logic                       overrun,
  output logic                       sync_err
);

  localparam int SW = ro_cnt_w(NSLOT);
  localparam int FW = NSLOT * BUSW;
  localparam logic [SW-1:0] SLOT_LAST = SW'(NSLOT - 1);
  localparam logic [SW-1:0] SLOT_NONE = SW'(NSLOT);
  localparam logic [2:0]    SKEW_LAST = 3'((SKEW > 0) ? (SKEW - 1) : 0);
  // With no skew the first slot is sampled right after the detected rise.
  localparam ro_state_e     ST_START  = (SKEW > 0) ? ST_WAIT : ST_CAPTURE;

  ro_state_e      state;
  ro_state_e      state_nxt;
  logic           sync_q;
  logic           armed;
  logic           rise;
  logic [2:0]     skew_cnt;
  logic [SW-1:0]  slot_cnt;
  logic [FW-1:0]  shreg;
  logic           start;
  logic           sample;
  logic           skew_inc;
  logic           load;
  logic           err_nxt;

  // armed stays low for the first cycle after reset so a frame_sync that is
  // already high at reset release is not mistaken for a rising edge.
  assign rise     = frame_sync & ~sync_q & armed;
  assign slot_idx = (state == ST_CAPTURE) ? slot_cnt : SLOT_NONE;

  // FSM state register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode; any rise restarts the frame from scratch.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    sample    = 1'b0;
    skew_inc  = 1'b0;
    load      = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nxt = ST_START;
          start     = 1'b1;
        end
      end
      ST_WAIT: begin
        if (rise) begin
          start   = 1'b1;
          err_nxt = 1'b1;
        end else if (skew_cnt == SKEW_LAST) begin
          state_nxt = ST_CAPTURE;
        end else begin
          skew_inc = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (rise) begin
          state_nxt = ST_START;
          start     = 1'b1;
          err_nxt   = 1'b1;
        end else begin
          sample = 1'b1;
          if (slot_cnt == SLOT_LAST) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        load = 1'b1;
        if (rise) begin
          state_nxt = ST_START;
          start     = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Edge detect, counters and slot shift register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q   <= 1'b0;
      armed    <= 1'b0;
      sync_err <= 1'b0;
      skew_cnt <= '0;
      slot_cnt <= '0;
      shreg    <= '0;
    end else begin
      sync_q   <= frame_sync;
      armed    <= 1'b1;
      sync_err <= err_nxt;
      if (start) begin
        skew_cnt <= '0;
        slot_cnt <= '0;
        shreg    <= '0;
      end else begin
        if (skew_inc) begin
          skew_cnt <= skew_cnt + 3'd1;
        end
        if (sample) begin
          slot_cnt <= slot_cnt + 1'b1;
          for (int k = 0; k < NSLOT; k++) begin
            if (slot_cnt == SW'(k)) begin
              shreg[k*BUSW +: BUSW] <= bus_in;
            end
          end
        end
      end
    end
  end

  ro_out_skid #(
    .W(FW)
  ) u_skid (
    .clk       (clk),
    .rstb      (rstb),
    .load      (load),
    .load_data (shreg),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_ro_bus_capture.sv
// Bench for ro_bus_capture: default geometry instance plus a SKEW=0, NSLOT=4
// instance. Accepted frames are checked against a scoreboard queue.
module tb_ro_bus_capture;

  logic        clk = 1'b0;
  logic        rstb;
  logic        frame_sync;
  logic [1:0]  bus_in;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  slot_idx;
  logic        overrun;
  logic        sync_err;

  logic        s_frame_sync;
  logic [1:0]  s_bus_in;
  logic        s_out_ready;
  logic        s_out_valid;
  logic [7:0]  s_out_data;
  logic [2:0]  s_slot_idx;
  logic        s_overrun;
  logic        s_sync_err;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    int          mode;
    logic [1:0]  val;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  ro_bus_capture #(.NSLOT(16), .BUSW(2), .SKEW(1)) u_dut (
    .clk        (clk),
    .rstb       (rstb),
    .frame_sync (frame_sync),
    .bus_in     (bus_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .slot_idx   (slot_idx),
    .overrun    (overrun),
    .sync_err   (sync_err)
  );

  ro_bus_capture #(.NSLOT(4), .BUSW(2), .SKEW(0)) u_sml (
    .clk        (clk),
    .rstb       (rstb),
    .frame_sync (s_frame_sync),
    .bus_in     (s_bus_in),
    .out_ready  (s_out_ready),
    .out_valid  (s_out_valid),
    .out_data   (s_out_data),
    .slot_idx   (s_slot_idx),
    .overrun    (s_overrun),
    .sync_err   (s_sync_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] slot_val(input int mode, input logic [1:0] val, input int k);
    case (mode)
      0:       return 2'(k % 4);
      1:       return val;
      2:       return 2'(3 - (k % 4));
      default: return 2'((k / 4) % 4);
    endcase
  endfunction

  // Issues a rise, drives 16 slots and returns in the DONE cycle. If abort_at
  // is a slot number, a second rise is issued there and the frame restarts.
  task automatic run_frame(input int mode, input logic [1:0] val, input int abort_at);
    frame_sync = 1'b1;
    tick;
    frame_sync = 1'b0;
    chk("wait_slot_idx", 64'(slot_idx), 64'(16));
    tick;
    for (int k = 0; k < 16; k++) begin
      bus_in = slot_val(mode, val, k);
      chk("slot_idx", 64'(slot_idx), 64'(k));
      if (k == abort_at) begin
        frame_sync = 1'b1;
        tick;
        frame_sync = 1'b0;
        chk("abort_sync_err", 64'(sync_err), 64'(1));
        chk("abort_slot_idx", 64'(slot_idx), 64'(16));
        tick;
        abort_at = -1;
        k = -1;
      end else begin
        tick;
      end
    end
    chk("done_slot_idx", 64'(slot_idx), 64'(16));
  endtask

  task automatic accept_one;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("valid_after_accept", 64'(out_valid), 64'(0));
  endtask

  // Scoreboard: every handshake pops the expected frame.
  always @(negedge clk) begin
    if (rstb && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got frame %h, expected no frame", out_data);
      end else begin
        chk("sb_accept", 64'(out_data), 64'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    int seen;
    vecs[0] = '{0, 2'd0, 32'hE4E4E4E4};
    vecs[1] = '{2, 2'd0, 32'h1B1B1B1B};
    vecs[2] = '{1, 2'd0, 32'h00000000};
    vecs[3] = '{1, 2'd3, 32'hFFFFFFFF};
    vecs[4] = '{3, 2'd0, 32'hFFAA5500};
    vecs[5] = '{1, 2'd1, 32'h55555555};

    rstb = 1'b0; frame_sync = 1'b0; bus_in = '0; out_ready = 1'b0;
    s_frame_sync = 1'b0; s_bus_in = '0; s_out_ready = 1'b0;
    tick;
    tick;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_slot_idx", 64'(slot_idx), 64'(16));
    chk("rst_overrun", 64'(overrun), 64'(0));
    chk("rst_sync_err", 64'(sync_err), 64'(0));
    chk("rst_s_slot_idx", 64'(s_slot_idx), 64'(4));
    rstb = 1'b1;
    repeat (6) tick;

    // Basic frame: slot k = k%4.
    run_frame(0, 2'd0, -1);
    chk("done_not_valid", 64'(out_valid), 64'(0));
    tick;
    chk("basic_valid", 64'(out_valid), 64'(1));
    chk("basic_data", 64'(out_data), 64'(32'hE4E4E4E4));
    chk("basic_overrun", 64'(overrun), 64'(0));
    chk("basic_sync_err", 64'(sync_err), 64'(0));
    sb_q.push_back(32'hE4E4E4E4);
    accept_one;

    // Table of bus patterns.
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].mode, vecs[i].val, -1);
      tick;
      chk("tbl_valid", 64'(out_valid), 64'(1));
      chk("tbl_data", 64'(out_data), 64'(vecs[i].exp));
      sb_q.push_back(vecs[i].exp);
      accept_one;
    end

    // Overrun: downstream stalled across two frames.
    run_frame(1, 2'd1, -1);
    tick;
    sb_q.push_back(32'h55555555);
    run_frame(1, 2'd2, -1);
    tick;
    chk("ovr_pulse", 64'(overrun), 64'(1));
    chk("ovr_valid", 64'(out_valid), 64'(1));
    chk("ovr_data_held", 64'(out_data), 64'(32'h55555555));
    tick;
    chk("ovr_once", 64'(overrun), 64'(0));
    chk("ovr_data_still", 64'(out_data), 64'(32'h55555555));
    accept_one;

    // Accept of frame 1 in the same cycle frame 2 is loaded.
    run_frame(1, 2'd1, -1);
    tick;
    sb_q.push_back(32'h55555555);
    run_frame(1, 2'd2, -1);
    out_ready = 1'b1;
    sb_q.push_back(32'hAAAAAAAA);
    tick;
    out_ready = 1'b0;
    chk("sim_overrun", 64'(overrun), 64'(0));
    chk("sim_valid", 64'(out_valid), 64'(1));
    chk("sim_data", 64'(out_data), 64'(32'hAAAAAAAA));
    accept_one;

    // Rise reissued at slot 7 aborts and restarts the frame.
    run_frame(0, 2'd0, 7);
    chk("abort_no_valid", 64'(out_valid), 64'(0));
    chk("abort_err_once", 64'(sync_err), 64'(0));
    tick;
    chk("abort_next_valid", 64'(out_valid), 64'(1));
    chk("abort_next_data", 64'(out_data), 64'(32'hE4E4E4E4));
    sb_q.push_back(32'hE4E4E4E4);
    accept_one;

    // Reset mid-frame with a frame held and frame_sync left high.
    run_frame(1, 2'd3, -1);
    tick;
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    frame_sync = 1'b1;
    repeat (7) tick;
    chk("pre_rst_slot5", 64'(slot_idx), 64'(5));
    rstb = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_data", 64'(out_data), 64'(0));
    chk("mid_rst_slot_idx", 64'(slot_idx), 64'(16));
    chk("mid_rst_overrun", 64'(overrun), 64'(0));
    chk("mid_rst_sync_err", 64'(sync_err), 64'(0));
    tick;
    rstb = 1'b1;
    seen = 0;
    repeat (20) begin
      tick;
      if (slot_idx != 5'd16 || out_valid || sync_err) seen++;
    end
    chk("high_sync_ignored", 64'(seen), 64'(0));
    frame_sync = 1'b0;
    tick;
    run_frame(3, 2'd0, -1);
    tick;
    chk("post_rst_data", 64'(out_data), 64'(32'hFFAA5500));
    sb_q.push_back(32'hFFAA5500);
    accept_one;

    // SKEW=0, NSLOT=4 instance.
    s_frame_sync = 1'b1;
    tick;
    s_frame_sync = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_bus_in = 2'(k);
      chk("s_slot_idx", 64'(s_slot_idx), 64'(k));
      tick;
    end
    chk("s_done_not_valid", 64'(s_out_valid), 64'(0));
    chk("s_done_slot_idx", 64'(s_slot_idx), 64'(4));
    tick;
    chk("s_valid", 64'(s_out_valid), 64'(1));
    chk("s_data", 64'(s_out_data), 64'(8'hE4));
    chk("s_sync_err", 64'(s_sync_err), 64'(0));

    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ro_bus_capture.md
Name: ro_bus_capture

Overview:
- Receive-side end of the shared readout bus.
- After each rising edge of the div-32 frame strobe, the readout blocks drive the BUSW-bit bus one after another, one slot per clk cycle.
- This block samples each slot and packs NSLOT slots into one frame word.
- It presents the frame to the downstream digital interface through a valid/ready holding register, and flags frame overruns and sync errors.

Parameters:
- NSLOT, 16: number of readout slots per frame (2..32).
- BUSW, 2: readout bus width in bits.
- SKEW, 1: clk cycles from the detected frame_sync rise to the slot 0 sample (0..7); covers tbuf enable delay.

Ports:
- clk, input, 1: sampling clock (clk_ext rate); all state updates on posedge.
- rstb, input, 1: asynchronous active-low reset.
- frame_sync, input, 1: div-32 frame strobe, synchronous to clk; a rising edge starts a frame.
- bus_in, input, BUSW: readout bus. A floating (z/x) value is never sampled by design.
- out_ready, input, 1: downstream accepts the frame when high together with out_valid.
- out_valid, output, 1: a frame is held in out_data.
- out_data, output, NSLOT*BUSW: frame word; slot k occupies bits [k*BUSW +: BUSW].
- slot_idx, output, clog2(NSLOT+1): slot currently being sampled; NSLOT when not capturing.
- overrun, output, 1: one-cycle pulse when a completed frame is dropped.
- sync_err, output, 1: one-cycle pulse when frame_sync rises mid-frame.

Behaviour:
- Reset (rstb low, async):
  - State IDLE; out_valid=0; out_data=0; slot_idx=NSLOT; overrun=0; sync_err=0.
  - Shift register and counters cleared; sync_q=0.
- Edge detect: sync_q <= frame_sync each cycle; rise = frame_sync & ~sync_q. After reset, a frame_sync that is already high does not count as a rise.
- FSM states:
  - IDLE: on rise, go to WAIT if SKEW>0, otherwise to CAPTURE with slot 0 sampled on the next edge. Clear the skew counter and slot counter.
  - WAIT: count SKEW-1 cycles, then go to CAPTURE. On rise, restart WAIT and pulse sync_err.
  - CAPTURE:
    - Each cycle, shift bus_in into the shift register at slot position slot_idx, then slot_idx+1.
    - After slot NSLOT-1 is sampled, go to DONE.
    - On rise: pulse sync_err, discard the partial frame, clear slot_idx, go to WAIT (or restart CAPTURE when SKEW=0).
  - DONE, one cycle: transfer to the output register and return to IDLE. A rise in this same cycle is accepted as the next frame (go to WAIT) with no error.
- Timing: with a rise detected at cycle T, slot k is sampled on the clk edge at T+1+SKEW+k. The frame is transferred in DONE at T+1+SKEW+NSLOT, and out_valid is high from the following cycle.
- Output handshake:
  - Transfer at DONE happens when out_valid=0, or out_valid=1 with out_ready=1 in the same cycle (simultaneous accept and load: out_valid stays 1 with the new data).
  - If out_valid=1 and out_ready=0 at DONE: keep the old frame, drop the new one, pulse overrun.
  - out_valid falls the cycle after an accept, unless a load occurs in that accept cycle.
  - out_data is stable while out_valid=1 and out_ready=0.
- slot_idx counter: width clog2(NSLOT+1); it never wraps past NSLOT.
- Mid-frame async reset: everything clears immediately; the partial frame is lost; no overrun or sync_err pulse.

Decomposition:
- Shared package ro_pkg:
  - Constants RO_NSLOT=16, RO_BUSW=2.
  - State encoding localparams (IDLE/WAIT/CAPTURE/DONE).
  - Function for the slot counter width.
- One natural sub-module: ro_out_skid, the one-entry valid/ready holding register with the overrun/accept logic.
- Edge detect and FSM stay in ro_bus_capture.

Test Plan:
- Defaults. Rise at cycle 10; bus_in driven with slot k = k%4 for k=0..15 → out_valid at cycle 29; out_data=32'hE4E4E4E4; overrun=0, sync_err=0.
- out_ready held 0 across two frames (first all 2'b01, second all 2'b10) → second completion pulses overrun once; out_data stays 32'h55555555; after out_ready=1 for one cycle, out_valid=0.
- Simultaneous accept and load: out_ready=1 exactly in the DONE cycle of frame 2 → no overrun; out_valid stays 1; out_data switches to frame 2 value 32'hAAAAAAAA.
- Rise reissued at slot 7 of a capture → sync_err pulses once; no out_valid for the aborted frame; the next complete frame is captured correctly.
- rstb pulsed low at slot 5 → all outputs 0 and slot_idx=16 immediately; frame_sync already high after release is ignored until its next rise.
- SKEW=0, NSLOT=4, BUSW=2: rise at cycle 3 → slot 0 sampled at cycle 4; out_data=8'hE4 valid at cycle 9.
